// File: rtl/rv32i_pkg.sv
// RV32I opcode encodings and immediate-select bit positions shared by the decode stage.
// Latency: none (package). Backpressure: n/a.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int IMM_SEL_W = 6;
    localparam int IMM_I1    = 0;
    localparam int IMM_I2    = 1;
    localparam int IMM_S     = 2;
    localparam int IMM_B     = 3;
    localparam int IMM_U     = 4;
    localparam int IMM_J     = 5;

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational RV32I decode into one-hot immediate select, rd write-enable, illegal flag and fields.
// Latency: 0 cycles. Backpressure: none (pure logic). ID_ILLEGAL_CHK_EN enables illegal-instruction checks.
module imm_sel_decode
    import rv32i_pkg::*;
(
    input  logic [31:0]          i_inst,
    output logic [IMM_SEL_W-1:0] o_imm_sel,
    output logic                 o_rd_we,
    output logic                 o_illegal,
    output logic [24:0]          o_payload,
    output logic [4:0]           o_rs1,
    output logic [4:0]           o_rs2,
    output logic [4:0]           o_rd
);

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic                 w_shamt;
    logic [IMM_SEL_W-1:0] w_imm_sel;
    logic                 w_writes_rd;
    logic                 w_known;

    assign w_opcode  = i_inst[6:0];
    assign w_funct3  = i_inst[14:12];
    assign w_shamt   = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign o_payload = i_inst[31:7];
    assign o_rs1     = i_inst[19:15];
    assign o_rs2     = i_inst[24:20];
    assign o_rd      = i_inst[11:7];

    always_comb begin
        w_imm_sel   = '0;
        w_writes_rd = 1'b0;
        w_known     = 1'b1;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_imm_sel[IMM_U] = 1'b1;
                w_writes_rd      = 1'b1;
            end
            OPC_JAL: begin
                w_imm_sel[IMM_J] = 1'b1;
                w_writes_rd      = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
                w_imm_sel[IMM_I1] = 1'b1;
                w_writes_rd       = 1'b1;
            end
            OPC_MISC_MEM: w_imm_sel[IMM_I1] = 1'b1;
            OPC_OP_IMM: begin
                // shift-immediates carry a 5-bit shamt, not a 12-bit immediate
                if (w_shamt) w_imm_sel[IMM_I2] = 1'b1;
                else         w_imm_sel[IMM_I1] = 1'b1;
                w_writes_rd = 1'b1;
            end
            OPC_STORE:  w_imm_sel[IMM_S] = 1'b1;
            OPC_BRANCH: w_imm_sel[IMM_B] = 1'b1;
            OPC_OP:     w_writes_rd      = 1'b1;
            default:    w_known          = 1'b0;
        endcase
    end

`ifdef ID_ILLEGAL_CHK_EN
    logic w_bad_shift;

    always_comb begin
        w_bad_shift = 1'b0;
        if (w_opcode == OPC_OP_IMM && w_shamt) begin
            if (w_funct3 == 3'b101)
                w_bad_shift = (i_inst[31:25] != 7'b0000000) && (i_inst[31:25] != 7'b0100000);
            else
                w_bad_shift = (i_inst[31:25] != 7'b0000000);
        end
    end

    assign o_illegal = !w_known || (i_inst[1:0] != 2'b11) || w_bad_shift;
    assign o_imm_sel = o_illegal ? '0 : w_imm_sel;
    assign o_rd_we   = !o_illegal && w_writes_rd && (o_rd != 5'd0);
`else
    assign o_illegal = 1'b0;
    assign o_imm_sel = w_imm_sel;
    assign o_rd_we   = w_known && w_writes_rd && (o_rd != 5'd0);
`endif

endmodule

// File: rtl/id_stage_reg.sv
// Decode pipeline register feeding the immediate generator; flush drops held and incoming instructions.
// Latency: 1 cycle. Backpressure: in_ready_o = !out_valid_o | out_ready_i; outputs hold while stalled.
module id_stage_reg
    import rv32i_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] XLEN_ZERO = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_inst_i,
    input  logic [XLEN-1:0]      in_pc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [24:0]          out_inst_o,
    output logic [XLEN-1:0]      out_pc_o,
    output logic [IMM_SEL_W-1:0] imm_sel_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic                 rd_we_o,
    output logic                 illegal_o
);

    logic [IMM_SEL_W-1:0] w_imm_sel;
    logic                 w_rd_we;
    logic                 w_illegal;
    logic [24:0]          w_payload;
    logic [4:0]           w_rs1, w_rs2, w_rd;
    logic                 w_in_ready;
    logic                 w_load;

    logic                 r_valid;
    logic [IMM_SEL_W-1:0] r_imm_sel;
    logic                 r_rd_we;
    logic                 r_illegal;
    logic [24:0]          r_inst;
    logic [XLEN-1:0]      r_pc;
    logic [4:0]           r_rs1, r_rs2, r_rd;

    imm_sel_decode u_dec (
        .i_inst    (in_inst_i),
        .o_imm_sel (w_imm_sel),
        .o_rd_we   (w_rd_we),
        .o_illegal (w_illegal),
        .o_payload (w_payload),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_rd      (w_rd)
    );

    assign w_in_ready = !r_valid || out_ready_i;
    assign w_load     = in_valid_i && w_in_ready && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)      r_valid <= 1'b0;
        else if (flush_i)  r_valid <= 1'b0;
        else if (w_load)   r_valid <= 1'b1;
        else if (out_ready_i) r_valid <= 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_imm_sel <= '0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
            r_inst    <= '0;
            r_pc      <= XLEN_ZERO;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
        end else if (flush_i) begin
            r_imm_sel <= '0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
            r_pc      <= XLEN_ZERO;
        end else if (w_load) begin
            r_imm_sel <= w_imm_sel;
            r_rd_we   <= w_rd_we;
            r_illegal <= w_illegal;
            r_inst    <= w_payload;
            r_pc      <= in_pc_i;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
        end
    end

    // decoded controls must never leak from an empty stage
    assign imm_sel_o   = r_valid ? r_imm_sel : '0;
    assign rd_we_o     = r_valid && r_rd_we;
    assign illegal_o   = r_valid && r_illegal;
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_valid;
    assign out_inst_o  = r_inst;
    assign out_pc_o    = r_pc;
    assign rs1_o       = r_rs1;
    assign rs2_o       = r_rs2;
    assign rd_o        = r_rd;

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed self-checking bench for id_stage_reg; expectations follow ID_ILLEGAL_CHK_EN when defined.
module tb_id_stage_reg;

    logic        clk_i = 1'b0;
    logic        rst_n_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0] in_inst_i, in_pc_i, out_pc_o;
    logic [24:0] out_inst_o;
    logic [5:0]  imm_sel_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        rd_we_o, illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage_reg #(.XLEN(32), .XLEN_ZERO(32'd0)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_inst_o(out_inst_o), .out_pc_o(out_pc_o), .imm_sel_o(imm_sel_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .rd_we_o(rd_we_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        in_inst_i = '0; in_pc_i = '0;
        #3;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
        n_checks++; if (imm_sel_o !== 6'b0 || rd_we_o !== 1'b0 || illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl got %b/%b/%b want 0", imm_sel_o, rd_we_o, illegal_o); end
        n_checks++; if (out_pc_o !== 32'd0 || out_inst_o !== 25'd0) begin n_fail++; $display("FAIL reset_data got pc=%h inst=%h want 0", out_pc_o, out_inst_o); end
        tick(); rst_n_i = 1'b1; #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready_o); end
        // hold an instruction, then reset asynchronously between edges
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_inst_i = 32'h00500093; in_pc_i = 32'h40;
        tick(); in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h40) begin n_fail++; $display("FAIL pre_async_load got v=%b pc=%h want 1/40", out_valid_o, out_pc_o); end
        #2 rst_n_i = 1'b0; #1;
        n_checks++; if (out_valid_o !== 1'b0 || out_pc_o !== 32'd0 || imm_sel_o !== 6'b0 || rd_o !== 5'd0 || rd_we_o !== 1'b0) begin n_fail++; $display("FAIL async_reset got v=%b pc=%h imm=%b rd=%0d we=%b want all 0", out_valid_o, out_pc_o, imm_sel_o, rd_o, rd_we_o); end
        #1 rst_n_i = 1'b1; out_ready_i = 1'b1;
        tick();
        n_checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_async got rdy=%b v=%b want 1/0", in_ready_o, out_valid_o); end
    endtask

    task automatic test_addi();
        out_ready_i = 1'b1; in_valid_i = 1'b1; in_inst_i = 32'h00500093; in_pc_i = 32'h100;
        tick(); in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1 || imm_sel_o !== 6'b000001) begin n_fail++; $display("FAIL addi_sel got v=%b imm=%b want 1/000001", out_valid_o, imm_sel_o); end
        n_checks++; if (rd_o !== 5'd1 || rd_we_o !== 1'b1 || rs1_o !== 5'd0) begin n_fail++; $display("FAIL addi_regs got rd=%0d we=%b rs1=%0d want 1/1/0", rd_o, rd_we_o, rs1_o); end
        n_checks++; if (out_inst_o !== 25'h000A001 || out_pc_o !== 32'h100 || illegal_o !== 1'b0) begin n_fail++; $display("FAIL addi_data got inst=%h pc=%h ill=%b want 000a001/100/0", out_inst_o, out_pc_o, illegal_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0 || imm_sel_o !== 6'b0 || rd_we_o !== 1'b0) begin n_fail++; $display("FAIL addi_pop got v=%b imm=%b we=%b want 0/0/0", out_valid_o, imm_sel_o, rd_we_o); end
    endtask

    task automatic test_slli_sw();
        in_valid_i = 1'b1; in_inst_i = 32'h00309113; in_pc_i = 32'h104;
        tick();
        n_checks++; if (imm_sel_o !== 6'b000010 || rd_o !== 5'd2 || rs1_o !== 5'd1 || rd_we_o !== 1'b1) begin n_fail++; $display("FAIL slli got imm=%b rd=%0d rs1=%0d we=%b want 000010/2/1/1", imm_sel_o, rd_o, rs1_o, rd_we_o); end
        in_inst_i = 32'h0020A223; in_pc_i = 32'h108;
        tick(); in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1 || imm_sel_o !== 6'b000100 || rd_we_o !== 1'b0) begin n_fail++; $display("FAIL sw got v=%b imm=%b we=%b want 1/000100/0", out_valid_o, imm_sel_o, rd_we_o); end
        n_checks++; if (rs1_o !== 5'd1 || rs2_o !== 5'd2 || out_pc_o !== 32'h108) begin n_fail++; $display("FAIL sw_regs got rs1=%0d rs2=%0d pc=%h want 1/2/108", rs1_o, rs2_o, out_pc_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_inst_i = 32'h00208463; in_pc_i = 32'h200;
        tick();
        in_inst_i = 32'h008000EF; in_pc_i = 32'h204;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid_o !== 1'b1 || imm_sel_o !== 6'b001000 || out_pc_o !== 32'h200 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_%0d got v=%b imm=%b pc=%h rdy=%b want 1/001000/200/0", i, out_valid_o, imm_sel_o, out_pc_o, in_ready_o); end
            tick();
        end
        out_ready_i = 1'b1; #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", in_ready_o); end
        tick(); in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1 || imm_sel_o !== 6'b100000 || out_pc_o !== 32'h204 || rd_o !== 5'd1 || rd_we_o !== 1'b1) begin n_fail++; $display("FAIL jal_no_bubble got v=%b imm=%b pc=%h rd=%0d we=%b want 1/100000/204/1/1", out_valid_o, imm_sel_o, out_pc_o, rd_o, rd_we_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL jal_drain got v=%b want 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_inst_i = 32'h00500093; in_pc_i = 32'h300;
        tick();
        flush_i = 1'b1; in_inst_i = 32'h0020A223; in_pc_i = 32'h304;
        tick(); flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        n_checks++; if (out_valid_o !== 1'b0 || imm_sel_o !== 6'b0 || out_pc_o !== 32'd0) begin n_fail++; $display("FAIL flush got v=%b imm=%b pc=%h want 0/0/0", out_valid_o, imm_sel_o, out_pc_o); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (out_valid_o !== 1'b0 || out_pc_o === 32'h304) begin n_fail++; $display("FAIL flush_drop_%0d got v=%b pc=%h want 0/not 304", i, out_valid_o, out_pc_o); end
        end
        // flush while downstream is ready: incoming still dropped
        in_valid_i = 1'b1; flush_i = 1'b1; in_pc_i = 32'h308;
        tick(); flush_i = 1'b0; in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got v=%b want 0", out_valid_o); end
    endtask

    task automatic test_illegal();
        logic       exp_ill;
        logic [5:0] exp_imm;
        logic       exp_we;
        out_ready_i = 1'b1; in_valid_i = 1'b1; in_inst_i = 32'h0000007F; in_pc_i = 32'h400;
`ifdef ID_ILLEGAL_CHK_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        tick();
        n_checks++; if (illegal_o !== exp_ill || imm_sel_o !== 6'b0 || rd_we_o !== 1'b0) begin n_fail++; $display("FAIL unknown_opc got ill=%b imm=%b we=%b want %b/0/0", illegal_o, imm_sel_o, rd_we_o, exp_ill); end
        in_inst_i = 32'h40309113;
`ifdef ID_ILLEGAL_CHK_EN
        exp_ill = 1'b1; exp_imm = 6'b000000; exp_we = 1'b0;
`else
        exp_ill = 1'b0; exp_imm = 6'b000010; exp_we = 1'b1;
`endif
        tick();
        n_checks++; if (illegal_o !== exp_ill || imm_sel_o !== exp_imm || rd_we_o !== exp_we) begin n_fail++; $display("FAIL bad_slli got ill=%b imm=%b we=%b want %b/%b/%b", illegal_o, imm_sel_o, rd_we_o, exp_ill, exp_imm, exp_we); end
        in_inst_i = 32'h4030D113;
        tick(); in_valid_i = 1'b0;
        n_checks++; if (illegal_o !== 1'b0 || imm_sel_o !== 6'b000010 || rd_we_o !== 1'b1) begin n_fail++; $display("FAIL srai got ill=%b imm=%b we=%b want 0/000010/1", illegal_o, imm_sel_o, rd_we_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_slli_sw();
        test_back_to_back();
        test_flush();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
